lcd_cmd_seq: RTL and testbench

//  Host-side command initiator for the LCD controller's cmd/cmd_valid/busy/done interface.

---
 rtl/lcd_cmd_seq.sv | 180 ++++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: host-side command initiator for the LCD controller.
//
// Commands are pushed into a small FIFO and issued one at a time on the
// controller's cmd/cmd_valid handshake, each only when busy is low. After
// command 15 is issued and acknowledged, the sequencer waits for done and
// then parks in FINISH until reset.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   push, push_cmd  enqueue a 4-bit command; push_ready = FIFO not full
//   start           1-cycle pulse, leaves IDLE
//   cmd, cmd_valid  registered command and 1-cycle issue strobe
//   busy, done      controller status inputs
//   fifo_count      entries currently held
//   issued_cnt      saturating count of issued commands
//   seq_done        sticky, done seen after cmd 15
//   err_ack_to      sticky, busy never rose after an issue
//   err_overflow    sticky, push while full
module lcd_cmd_seq #(
  parameter int          DEPTH    = 16,
  parameter int          AW       = 4,
  parameter logic [3:0]  IDLE_CMD = 4'hE,
  parameter int          ACK_TO   = 8,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [3:0]       push_cmd,
  output logic             push_ready,
  input  logic             start,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic [AW:0]      fifo_count,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             seq_done,
  output logic             err_ack_to,
  output logic             err_overflow
);

  localparam int          TO_W   = $clog2(ACK_TO + 1);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_C = TO_W'(ACK_TO);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              seq_done_q, seq_done_d;
  logic              err_ack_q, err_ack_d;
  logic              err_ovf_q, err_ovf_d;
  logic              last15_q, last15_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic full, push_ok, pop;

  // FIFO bookkeeping. Pushes are dropped silently in FINISH.
  always_comb begin
    full       = (count_q == FULL_C);
    push_ready = !full;
    push_ok    = push && !full && (state_q != S_FINISH);
    pop        = (state_q == S_WAIT_RDY) && !busy && (count_q != '0);

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    err_ovf_d = err_ovf_q || (push && full && (state_q != S_FINISH));
  end

  // Sequencer. cmd/cmd_valid default to idle so only the issue edge drives them.
  always_comb begin
    state_d     = state_q;
    cmd_d       = IDLE_CMD;
    cmd_valid_d = 1'b0;
    issued_d    = issued_q;
    seq_done_d  = seq_done_q;
    err_ack_d   = err_ack_q;
    last15_d    = last15_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_WAIT_RDY;

      S_WAIT_RDY: begin
        if (pop) begin
          cmd_d       = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          last15_d    = (mem_q[rd_ptr_q] == 4'hF);
          if (issued_q != '1) issued_d = issued_q + 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (busy) begin
          state_d = last15_q ? S_WAIT_DONE : S_WAIT_RDY;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          // Lost command is abandoned, not re-issued.
          if (to_cnt_d == TO_C) begin
            err_ack_d = 1'b1;
            state_d   = S_WAIT_RDY;
          end
        end
      end

      S_WAIT_DONE: begin
        if (done) begin
          seq_done_d = 1'b1;
          state_d    = S_FINISH;
        end
      end

      S_FINISH: state_d = S_FINISH;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_q       <= IDLE_CMD;
      cmd_valid_q <= 1'b0;
      issued_q    <= '0;
      seq_done_q  <= 1'b0;
      err_ack_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      last15_q    <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      issued_q    <= issued_d;
      seq_done_q  <= seq_done_d;
      err_ack_q   <= err_ack_d;
      err_ovf_q   <= err_ovf_d;
      last15_q    <= last15_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_cmd;
  end

  assign cmd          = cmd_q;
  assign cmd_valid    = cmd_valid_q;
  assign fifo_count   = count_q;
  assign issued_cnt   = issued_q;
  assign seq_done     = seq_done_q;
  assign err_ack_to   = err_ack_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq. Inputs change on the falling edge; a
// monitor samples 1 time unit after each rising edge, logs issued commands
// and optionally plays a controller that raises busy for 2 cycles per command.
module tb_lcd_cmd_seq;
  logic        clk = 1'b0, rst = 1'b0;
  logic        push = 1'b0, start = 1'b0, busy = 1'b0, done = 1'b0;
  logic [3:0]  push_cmd = 4'h0;
  logic        push_ready, cmd_valid, seq_done, err_ack_to, err_overflow;
  logic [3:0]  cmd;
  logic [4:0]  fifo_count;
  logic [15:0] issued_cnt;

  int checks = 0, errors = 0;
  logic [3:0] log_q [$];
  int bmode = 0, bcnt = 0, bad_zero = 0, bad_pulse = 0;
  logic prev_v = 1'b0;

  lcd_cmd_seq dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_ready(push_ready),
    .start(start), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .fifo_count(fifo_count), .issued_cnt(issued_cnt), .seq_done(seq_done),
    .err_ack_to(err_ack_to), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (cmd_valid) log_q.push_back(cmd);
    if (cmd_valid && prev_v) bad_pulse++;
    if (cmd == 4'h0 && !cmd_valid) bad_zero++;
    prev_v = cmd_valid;
    if (bmode == 1) begin
      if (cmd_valid) begin
        busy = 1'b1;
        bcnt = 2;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) busy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] lg(input int i);
    return (i < log_q.size()) ? {1'b0, log_q[i]} : 5'h1F;
  endfunction

  task automatic do_reset();
    bmode = 0; bcnt = 0;
    rst = 1'b0; push = 1'b0; start = 1'b0; busy = 1'b0; done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    log_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_one(input logic [3:0] c);
    push = 1'b1; push_cmd = c;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, log_q.size(), n);
  endtask

  initial begin : main
    int bad, k;
    logic [3:0] prev, v;

    // 1) reset state, then {1,5,15} to completion
    do_reset();
    chk("rst_cmd", cmd, 4'hE);
    chk("rst_vld", cmd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_flags", {seq_done, err_ack_to, err_overflow}, 0);
    chk("rst_ready", push_ready, 1);
    push_one(4'd1); push_one(4'd5); push_one(4'd15);
    chk("t1_count", fifo_count, 3);
    bmode = 1;
    pulse_start();
    wait_log(3, 100, "t1_n");
    chk("t1_c0", lg(0), 1);
    chk("t1_c1", lg(1), 5);
    chk("t1_c2", lg(2), 15);
    chk("t1_issued", issued_cnt, 3);
    chk("t1_no_done_yet", seq_done, 0);
    repeat (3) @(negedge clk);
    done = 1'b1;
    k = 0;
    while (!seq_done && k < 10) begin @(negedge clk); k++; end
    done = 1'b0;
    chk("t1_seq_done", seq_done, 1);
    push_one(4'd3);
    chk("t1_finish_push", fifo_count, 0);
    chk("t1_finish_ovf", err_overflow, 0);
    repeat (5) @(negedge clk);
    chk("t1_finish_issued", issued_cnt, 3);

    // 2) overflow on the 17th push, then all 16 issue in order
    do_reset();
    for (int i = 0; i < 16; i++) push_one(4'(i));
    chk("t2_ready", push_ready, 0);
    chk("t2_count16", fifo_count, 16);
    chk("t2_ovf0", err_overflow, 0);
    push_one(4'd9);
    chk("t2_ovf1", err_overflow, 1);
    chk("t2_count", fifo_count, 16);
    bmode = 1;
    pulse_start();
    wait_log(16, 300, "t2_n");
    for (int i = 0; i < 16; i++) chk("t2_order", lg(i), 5'(i));
    chk("t2_issued", issued_cnt, 16);
    repeat (6) @(negedge clk);
    chk("t2_empty", fifo_count, 0);
    chk("t2_n_final", log_q.size(), 16);

    // 3) busy held high in WAIT_RDY
    do_reset();
    busy = 1'b1;
    push_one(4'd7);
    pulse_start();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd !== 4'hE || cmd_valid !== 1'b0) bad++;
    end
    chk("t3_hold", bad, 0);
    busy = 1'b0;
    @(negedge clk);
    chk("t3_vld", cmd_valid, 1);
    chk("t3_cmd", cmd, 7);
    busy = 1'b1;
    @(negedge clk);
    chk("t3_vld_off", cmd_valid, 0);
    chk("t3_cmd_idle", cmd, 4'hE);
    @(negedge clk);
    busy = 1'b0;

    // 4) no ack: timeout after 8 cycles, next command issues, no repeat
    do_reset();
    push_one(4'd2); push_one(4'd3);
    pulse_start();
    wait_log(1, 20, "t4_n1");
    repeat (8) @(negedge clk);
    chk("t4_err_early", err_ack_to, 0);
    @(negedge clk);
    chk("t4_err", err_ack_to, 1);
    chk("t4_gap", cmd_valid, 0);
    @(negedge clk);
    chk("t4_vld", cmd_valid, 1);
    chk("t4_cmd", cmd, 3);
    repeat (20) @(negedge clk);
    chk("t4_n", log_q.size(), 2);
    chk("t4_c0", lg(0), 2);
    chk("t4_c1", lg(1), 3);
    chk("t4_issued", issued_cnt, 2);

    // 5) simultaneous push/pop at count=1, 40 times across pointer wrap
    do_reset();
    busy = 1'b1;
    push_one(4'd9);
    pulse_start();
    @(negedge clk);
    prev = 4'd9;
    for (int i = 0; i < 40; i++) begin
      v = 4'((i * 7) % 15);
      busy = 1'b0; push = 1'b1; push_cmd = v;
      @(negedge clk);
      push = 1'b0; busy = 1'b1;
      chk("t5_count", fifo_count, 1);
      chk("t5_vld", cmd_valid, 1);
      chk("t5_cmd", cmd, prev);
      prev = v;
      repeat (2) @(negedge clk);
    end
    chk("t5_n", log_q.size(), 40);
    busy = 1'b0;

    // 6) reset while in ISSUE
    do_reset();
    bmode = 1;
    for (int i = 0; i < 17; i++) push_one(4'(i % 16));
    chk("t6_ovf", err_overflow, 1);
    pulse_start();
    k = 0;
    while (!cmd_valid && k < 10) begin @(negedge clk); k++; end
    chk("t6_in_issue", cmd_valid, 1);
    rst = 1'b0;
    #1;
    chk("t6_vld", cmd_valid, 0);
    chk("t6_cmd", cmd, 4'hE);
    chk("t6_count", fifo_count, 0);
    chk("t6_issued", issued_cnt, 0);
    chk("t6_flags", {seq_done, err_ack_to, err_overflow}, 0);
    chk("t6_ready", push_ready, 1);
    bmode = 0; busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("single_cycle_valid", bad_pulse, 0);
    chk("cmd0_only_issue", bad_zero, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
